// File: rtl/fabric_tx_buffer.sv
// ----------------------------------------------------------------------------
// fabric_tx_buffer
//
// Egress frame buffer for one switch output interface. It watches one crossbar
// channel, keeps only the frames addressed to PORT_ID whose VLAN matches
// port_vlan, and stores them store-and-forward: a frame becomes visible to the
// TX MAC only after its last word is written. A frame that runs out of space
// is rolled back by rewinding the write pointer to the last commit point.
// Committed words stream out through a prefetch stage and a one-word output
// register using a valid/ready handshake.
//
// Parameters
//   PORT_ID          fabric port number of this interface (5 bits)
//   DEPTH            buffer depth in 64-bit words (power of two, >= 4)
//
// Ports
//   clk              fabric clock
//   rst              asynchronous active-high reset
//   xbar_valid       channel word valid, high for the whole frame
//   xbar_dest_port   channel destination port, stable during a frame
//   xbar_vlan        frame VLAN, stable during a frame
//   xbar_bytes_valid valid bytes (1..8), meaningful on the last word only
//   xbar_data        frame data
//   port_vlan        VLAN of this interface (quasi-static)
//   tx_valid         output word valid
//   tx_ready         TX MAC accepts the word
//   tx_data          output data
//   tx_bytes_valid   8 on non-last words, 1..8 on the last word
//   tx_last          last word of the frame
//   drop_vlan        one-cycle pulse: frame for this port had the wrong VLAN
//   drop_overflow    one-cycle pulse: frame discarded for lack of space
//   free_words       DEPTH minus committed and in-progress words
// ----------------------------------------------------------------------------
module fabric_tx_buffer #(
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned DEPTH   = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     xbar_valid,
  input  logic [4:0]               xbar_dest_port,
  input  logic [11:0]              xbar_vlan,
  input  logic [3:0]               xbar_bytes_valid,
  input  logic [63:0]              xbar_data,
  input  logic [11:0]              port_vlan,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [63:0]              tx_data,
  output logic [3:0]               tx_bytes_valid,
  output logic                     tx_last,
  output logic                     drop_vlan,
  output logic                     drop_overflow,
  output logic [$clog2(DEPTH):0]   free_words
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);
  localparam logic [4:0]  C_PORT  = 5'(PORT_ID);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCEPT   = 2'd1,
    S_DISCARD  = 2'd2,
    S_OVERFLOW = 2'd3
  } state_t;

  // Storage entry layout: {last, bytes_valid[3:0], data[63:0]}
  logic [68:0]  r_mem [DEPTH];

  // Ingress state
  state_t       r_state;
  logic         r_valid_ff;
  logic [63:0]  r_hold_data;
  logic [3:0]   r_hold_bv;
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_commit_ptr;
  logic         r_drop_vlan;
  logic         r_drop_overflow;

  // Egress state. r_rd_ptr releases an entry when the MAC takes it;
  // r_fetch_ptr runs ahead of it feeding the prefetch stage.
  logic [AW:0]  r_rd_ptr;
  logic [AW:0]  r_fetch_ptr;
  logic         r_pf_valid;
  logic [68:0]  r_pf_word;
  logic         r_tx_valid;
  logic [63:0]  r_tx_data;
  logic [3:0]   r_tx_bv;
  logic         r_tx_last;
  logic [AW:0]  r_free_words;

  // Ingress decode
  logic         w_start;
  logic [AW:0]  w_used;
  logic         w_full;
  logic         w_accept;
  logic         w_wr_en;
  logic         w_rewind;
  logic [68:0]  w_wr_word;
  logic [AW:0]  w_wr_ptr_next;

  // Egress decode
  logic         w_tx_fire;
  logic         w_out_load;
  logic         w_fetch;
  logic [AW:0]  w_rd_ptr_next;

  // A start needs a low-to-high transition on xbar_valid; valid_ff resets
  // high so a frame already in flight at reset release is never truncated.
  assign w_start  = xbar_valid & ~r_valid_ff;

  // Occupancy is measured against the release pointer, so words sitting in
  // the prefetch stage or the output register still count as used.
  assign w_used   = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_used == C_DEPTH);

  // In ACCEPT every cycle writes the held word: a middle word while the
  // frame continues, or the last word on the first idle cycle.
  assign w_accept = (r_state == S_ACCEPT);
  assign w_wr_en  = w_accept & ~w_full;
  assign w_rewind = w_accept &  w_full;

  assign w_wr_word = {~xbar_valid,
                      (xbar_valid ? 4'd8 : r_hold_bv),
                      r_hold_data};

  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    if (w_rewind) begin
      w_wr_ptr_next = r_commit_ptr;
    end else if (w_wr_en) begin
      w_wr_ptr_next = r_wr_ptr + C_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Ingress FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_valid_ff      <= 1'b1;
      r_hold_data     <= '0;
      r_hold_bv       <= '0;
      r_wr_ptr        <= '0;
      r_commit_ptr    <= '0;
      r_drop_vlan     <= 1'b0;
      r_drop_overflow <= 1'b0;
    end else begin
      r_valid_ff      <= xbar_valid;
      r_wr_ptr        <= w_wr_ptr_next;
      r_drop_vlan     <= 1'b0;
      r_drop_overflow <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (xbar_valid) begin
            if (!w_start || (xbar_dest_port != C_PORT)) begin
              // Not ours, or joined mid-frame: silently skip.
              r_state <= S_DISCARD;
            end else if (xbar_vlan != port_vlan) begin
              r_state     <= S_DISCARD;
              r_drop_vlan <= 1'b1;
            end else begin
              r_state     <= S_ACCEPT;
              r_hold_data <= xbar_data;
              r_hold_bv   <= xbar_bytes_valid;
            end
          end
        end

        S_ACCEPT: begin
          if (w_full) begin
            // Pointer rewind happens through w_wr_ptr_next.
            r_drop_overflow <= 1'b1;
            r_state         <= xbar_valid ? S_OVERFLOW : S_IDLE;
          end else if (xbar_valid) begin
            r_hold_data <= xbar_data;
            r_hold_bv   <= xbar_bytes_valid;
          end else begin
            // Last word written this edge: publish the frame.
            r_commit_ptr <= r_wr_ptr + C_ONE;
            r_state      <= S_IDLE;
          end
        end

        S_DISCARD, S_OVERFLOW: begin
          if (!xbar_valid) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Egress: fetch -> prefetch register -> output register
  // --------------------------------------------------------------------------
  assign w_tx_fire  = r_tx_valid & tx_ready;
  assign w_out_load = r_pf_valid & (~r_tx_valid | tx_ready);

  // Fetch only committed entries, and only when the prefetch register will
  // be free after this edge. That keeps both stages full under sustained
  // tx_ready without ever needing a skid buffer.
  assign w_fetch    = (r_fetch_ptr != r_commit_ptr) & (~r_pf_valid | w_out_load);

  assign w_rd_ptr_next = w_tx_fire ? (r_rd_ptr + C_ONE) : r_rd_ptr;

  // Simple dual-port memory with registered read. The read address is always
  // a committed entry and the write address never is, so they cannot collide.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wr_word;
    end
    if (w_fetch) begin
      r_pf_word <= r_mem[r_fetch_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_ptr <= '0;
      r_rd_ptr    <= '0;
      r_pf_valid  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_tx_bv     <= '0;
      r_tx_last   <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_next;

      if (w_fetch) begin
        r_fetch_ptr <= r_fetch_ptr + C_ONE;
        r_pf_valid  <= 1'b1;
      end else if (w_out_load) begin
        r_pf_valid  <= 1'b0;
      end

      if (w_out_load) begin
        r_tx_valid <= 1'b1;
        r_tx_last  <= r_pf_word[68];
        r_tx_bv    <= r_pf_word[67:64];
        r_tx_data  <= r_pf_word[63:0];
      end else if (w_tx_fire) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  // Free space after this edge's write, rewind and release all take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_free_words <= C_DEPTH;
    end else begin
      r_free_words <= C_DEPTH - (w_wr_ptr_next - w_rd_ptr_next);
    end
  end

  assign tx_valid       = r_tx_valid;
  assign tx_data        = r_tx_data;
  assign tx_bytes_valid = r_tx_bv;
  assign tx_last        = r_tx_last;
  assign drop_vlan      = r_drop_vlan;
  assign drop_overflow  = r_drop_overflow;
  assign free_words     = r_free_words;

endmodule
